// File: rtl/fll_cfg_pkg.sv
// Shared types for the FLL configuration controller.
// Optional macro FLL_CFG_TIMEOUT_EN adds the ERR state.
package fll_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_DONE
`ifdef FLL_CFG_TIMEOUT_EN
    ,
    S_ERR
`endif
  } state_t;

  localparam logic [2:0] FLL_REG0   = 3'd0;
  localparam logic [2:0] FLL_REG1   = 3'd1;
  localparam logic [2:0] FLL_REG2   = 3'd2;
  localparam logic [2:0] FLL_REG3   = 3'd3;
  localparam logic [2:0] FLL_STATUS = 3'd4;

  localparam int ST_LOCK      = 0;
  localparam int ST_LOCK_LOST = 1;
  localparam int ST_TIMEOUT   = 2;

  function automatic logic is_fll_reg(
    input logic [2:0] idx
  );
    return idx inside {FLL_REG0, FLL_REG1,
                       FLL_REG2, FLL_REG3};
  endfunction

  function automatic logic is_bad(
    input logic [2:0] idx
  );
    return idx > FLL_STATUS;
  endfunction

endpackage

// File: rtl/fll_cfg_if.sv
// APB slave bundle for the FLL configuration controller.
// Signal names keep the block's external pin names.
interface fll_cfg_if;

  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport master (
    output psel_i,
    output penable_i,
    output pwrite_i,
    output paddr_i,
    output pwdata_i,
    input  prdata_o,
    input  pready_o,
    input  pslverr_o
  );

  modport slave (
    input  psel_i,
    input  penable_i,
    input  pwrite_i,
    input  paddr_i,
    input  pwdata_i,
    output prdata_o,
    output pready_o,
    output pslverr_o
  );

endinterface

// File: rtl/fll_cfg_sync.sv
// Multi-flop synchronizer for one asynchronous bit.
// Flops clear on synchronous reset.
module fll_cfg_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/fll_cfg_ctrl.sv
// APB to FLL 4-phase config bridge with local STATUS reg.
// Define FLL_CFG_TIMEOUT_EN for the handshake timeout/ERR path.
module fll_cfg_ctrl
  import fll_cfg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fll_cfg_if.slave    apb,
  output logic        fll_req_o,
  output logic        fll_wrn_o,
  output logic [1:0]  fll_add_o,
  output logic [31:0] fll_data_o,
  input  logic        fll_ack_i,
  input  logic [31:0] fll_r_data_i,
  input  logic        fll_lock_i,
  output logic        lock_o
);

  localparam logic [31:0] TO_BITS =
    32'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic        access;
  logic [2:0]  idx;
  logic        ack_sync;
  logic        lock_sync;
  logic        lock_q;
  logic        lock_fall;
  logic        latch;
  logic        rd_cap;
  logic        st_acc;
  logic        st_wr;
  logic        bad_q;
  logic        lost_q;
  logic        to_bit;
  logic [31:0] status;
  logic [31:0] prdata_q;
  logic        wrn_q;
  logic [1:0]  add_q;
  logic [31:0] data_q;
  logic        unused_ok;

  assign access = apb.psel_i & apb.penable_i;
  assign idx    = apb.paddr_i[4:2];
  assign st_wr  = st_acc & apb.pwrite_i;

  assign unused_ok = ^{apb.paddr_i[11:5],
                       apb.paddr_i[1:0],
                       TO_BITS};

  fll_cfg_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (fll_ack_i),
    .q     (ack_sync)
  );

  fll_cfg_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (fll_lock_i),
    .q     (lock_sync)
  );

`ifdef FLL_CFG_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ?
    $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic          busy;
  logic          timeout;
  logic          to_set;
  logic          to_q;

  assign busy    = (state == S_REQ) ||
                   (state == S_RELEASE);
  assign timeout = busy &&
    (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Any state change restarts the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_q <= 1'b0;
    end else begin
      to_q <= (to_q &
               ~(st_wr & apb.pwdata_i[ST_TIMEOUT]))
              | to_set;
    end
  end

  assign to_bit = to_q;
`else
  assign to_bit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    rd_cap   = 1'b0;
    st_acc   = 1'b0;
`ifdef FLL_CFG_TIMEOUT_EN
    to_set   = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (access) begin
          unique case (1'b1)
            is_fll_reg(idx): begin
              if (!ack_sync) begin
                state_nx = S_REQ;
                latch    = 1'b1;
              end
            end
            (idx == FLL_STATUS): begin
              state_nx = S_DONE;
              st_acc   = 1'b1;
            end
            is_bad(idx): state_nx = S_DONE;
            default: ;
          endcase
        end
      end
      S_REQ: begin
        if (ack_sync) begin
          state_nx = S_RELEASE;
          rd_cap   = wrn_q;
        end
`ifdef FLL_CFG_TIMEOUT_EN
        if (timeout) begin
          state_nx = S_ERR;
          rd_cap   = 1'b0;
          to_set   = 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!ack_sync) begin
          state_nx = S_DONE;
        end
`ifdef FLL_CFG_TIMEOUT_EN
        if (timeout) begin
          state_nx = S_ERR;
          to_set   = 1'b1;
        end
`endif
      end
      S_DONE: state_nx = S_IDLE;
`ifdef FLL_CFG_TIMEOUT_EN
      S_ERR:  state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request fields frozen from REQ entry to DONE exit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrn_q  <= 1'b1;
      add_q  <= 2'd0;
      data_q <= '0;
    end else if (latch) begin
      wrn_q <= ~apb.pwrite_i;
      add_q <= idx[1:0];
      if (apb.pwrite_i) begin
        data_q <= apb.pwdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bad_q <= 1'b0;
    end else if (state == S_IDLE) begin
      bad_q <= access & is_bad(idx);
    end
  end

  assign lock_fall = lock_q & ~lock_sync;

  // A new lock loss beats a same-cycle clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      lock_q <= lock_sync;
      lost_q <= (lost_q &
                 ~(st_wr & apb.pwdata_i[ST_LOCK_LOST]))
                | lock_fall;
    end
  end

  always_comb begin
    status               = '0;
    status[ST_LOCK]      = lock_sync;
    status[ST_LOCK_LOST] = lost_q;
    status[ST_TIMEOUT]   = to_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prdata_q <= '0;
    end else if (rd_cap) begin
      prdata_q <= fll_r_data_i;
    end else if (st_acc && !apb.pwrite_i) begin
      prdata_q <= status;
    end
  end

  assign fll_req_o  = (state == S_REQ);
  assign fll_wrn_o  = wrn_q;
  assign fll_add_o  = add_q;
  assign fll_data_o = data_q;
  assign lock_o     = lock_sync;

  assign apb.prdata_o = prdata_q;
`ifdef FLL_CFG_TIMEOUT_EN
  assign apb.pready_o  = (state == S_DONE) ||
                         (state == S_ERR);
  assign apb.pslverr_o = ((state == S_DONE) & bad_q) ||
                         (state == S_ERR);
`else
  assign apb.pready_o  = (state == S_DONE);
  assign apb.pslverr_o = (state == S_DONE) & bad_q;
`endif

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Bench for fll_cfg_ctrl: transaction model plus directed vectors.
// Timeout vectors run only with FLL_CFG_TIMEOUT_EN defined.
module tb_fll_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fll_req;
  logic        fll_wrn;
  logic [1:0]  fll_add;
  logic [31:0] fll_data;
  logic        fll_ack;
  logic [31:0] fll_rdata = '0;
  logic        fll_lock = 1'b1;
  logic        lock;
  logic        ack_mode = 1'b0;
  logic        ack_force = 1'b0;

  always #5 clk = ~clk;

  fll_cfg_if apb ();

  assign fll_ack = ack_mode ? ack_force : fll_req;

  fll_cfg_ctrl #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .apb          (apb),
    .fll_req_o    (fll_req),
    .fll_wrn_o    (fll_wrn),
    .fll_add_o    (fll_add),
    .fll_data_o   (fll_data),
    .fll_ack_i    (fll_ack),
    .fll_r_data_i (fll_rdata),
    .fll_lock_i   (fll_lock),
    .lock_o       (lock)
  );

  int checks = 0;
  int errors = 0;

  // transaction-level expectations
  bit          exp_fll = 0;
  bit          exp_read = 0;
  bit          exp_err = 0;
  bit          exp_wrn = 1;
  logic [1:0]  exp_add = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] m_data = '0;
  bit          m_lock = 0;
  bit          m_lost = 0;
  bit          m_to = 0;
  int          req_rises = 0;
  bit          seen_req = 0;
  logic        req_d = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen_req = 0;
      req_d = 0;
    end else begin
      if (fll_req && !req_d) req_rises++;
      if (fll_req) seen_req = 1;
      if (fll_req && !exp_fll)
        chk("req_unexpected", 1, 0);
      if (seen_req) begin
        chk("fll_add", fll_add, exp_add);
        chk("fll_wrn", fll_wrn, exp_wrn);
        chk("fll_data", fll_data, m_data);
      end
      if (apb.pready_o) begin
        chk("pslverr", apb.pslverr_o, exp_err);
        chk("req_at_ready", fll_req, 0);
        if (exp_read && !exp_err)
          chk("prdata", apb.prdata_o, exp_rdata);
        seen_req = 0;
      end
      req_d = fll_req;
    end
  end

  // Called just after a rising edge; returns just after one.
  task automatic bus(input logic [2:0] idx,
                     input bit wr,
                     input logic [31:0] wd,
                     output int lat);
    apb.paddr_i   = {7'h0, idx, 2'b00};
    apb.pwrite_i  = wr;
    apb.pwdata_i  = wd;
    apb.psel_i    = 1'b1;
    apb.penable_i = 1'b0;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!apb.pready_o && lat < 300) begin
      lat++;
      @(negedge clk);
    end
    if (!apb.pready_o) chk("bus_timeout", 0, 1);
    @(posedge clk); #1;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
  endtask

  task automatic fll_txn(input logic [1:0] a,
                         input bit wr,
                         input logic [31:0] d,
                         input int exp_lat);
    int lat;
    exp_fll  = 1;
    exp_err  = 0;
    exp_add  = a;
    exp_wrn  = ~wr;
    exp_read = ~wr;
    if (wr) m_data = d;
    else begin
      fll_rdata = d;
      exp_rdata = d;
    end
    bus({1'b0, a}, wr, wr ? d : 32'h0, lat);
    chk("fll_latency", lat, exp_lat);
    exp_fll = 0;
  endtask

  task automatic st_rd();
    int lat;
    exp_fll   = 0;
    exp_err   = 0;
    exp_read  = 1;
    exp_rdata = {29'h0, m_to, m_lost, m_lock};
    bus(3'd4, 1'b0, 32'h0, lat);
    chk("status_rd_latency", lat, 1);
  endtask

  task automatic st_wr(input logic [31:0] d);
    int lat;
    exp_fll  = 0;
    exp_err  = 0;
    exp_read = 0;
    if (d[1]) m_lost = 0;
    if (d[2]) m_to = 0;
    bus(3'd4, 1'b1, d, lat);
    chk("status_wr_latency", lat, 1);
  endtask

  task automatic bad(input logic [2:0] idx);
    int lat;
    int r0;
    r0       = req_rises;
    exp_fll  = 0;
    exp_err  = 1;
    exp_read = 0;
    bus(idx, 1'b0, 32'h0, lat);
    chk("bad_latency", lat, 1);
    chk("bad_no_req", req_rises, r0);
    exp_err = 0;
  endtask

  initial begin
    int r0;
    int lat;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    apb.pwrite_i  = 1'b0;
    apb.paddr_i   = '0;
    apb.pwdata_i  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", fll_req, 0);
    chk("rst_wrn", fll_wrn, 1);
    chk("rst_add", fll_add, 0);
    chk("rst_data", fll_data, 0);
    chk("rst_prdata", apb.prdata_o, 0);
    chk("rst_pready", apb.pready_o, 0);
    chk("rst_pslverr", apb.pslverr_o, 0);
    chk("rst_lock", lock, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_lock = 1;
    repeat (4) @(posedge clk); #1;
    chk("lock_up", lock, 1);

    r0 = req_rises;
    fll_txn(2'd2, 1'b1, 32'hDEAD_BEEF, 7);
    chk("wr_one_pulse", req_rises, r0 + 1);
    chk("wr_add_lit", fll_add, 2);
    chk("wr_wrn_lit", fll_wrn, 0);
    chk("wr_data_lit", fll_data, 32'hDEAD_BEEF);

    fll_txn(2'd1, 1'b0, 32'h1234_5678, 7);
    chk("rd_prdata_lit", apb.prdata_o, 32'h1234_5678);
    chk("rd_wrn_lit", fll_wrn, 1);
    chk("rd_keeps_data", fll_data, 32'hDEAD_BEEF);

    fll_txn(2'd0, 1'b1, 32'hA5A5_0001, 7);
    chk("prdata_hold", apb.prdata_o, 32'h1234_5678);
    fll_txn(2'd3, 1'b0, 32'hCAFE_F00D, 7);

    st_rd();
    chk("status_lock_lit", apb.prdata_o, 32'h1);

    bad(3'd6);
    bad(3'd5);
    bad(3'd7);
    chk("bad_prdata_hold", apb.prdata_o, 32'h1);

    fll_lock = 1'b0;
    m_lock = 0;
    m_lost = 1;
    repeat (4) @(posedge clk); #1;
    st_rd();
    chk("lost_lit", apb.prdata_o, 32'h2);
    st_wr(32'h2);
    st_rd();
    chk("cleared_lit", apb.prdata_o, 32'h0);

    fll_lock = 1'b1;
    m_lock = 1;
    repeat (4) @(posedge clk); #1;
    st_rd();
    chk("relock_lit", apb.prdata_o, 32'h1);
    // lock_sync falls in the access cycle of the clear
    fll_lock = 1'b0;
    @(posedge clk); #1;
    st_wr(32'h2);
    m_lock = 0;
    m_lost = 1;
    st_rd();
    chk("set_wins_lit", apb.prdata_o, 32'h2);
    chk("lock_low", lock, 0);

    // reset while in RELEASE, ack held high
    exp_fll  = 1;
    exp_err  = 0;
    exp_read = 0;
    exp_add  = 2'd3;
    exp_wrn  = 0;
    m_data   = 32'h0BAD_F00D;
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    apb.paddr_i   = {7'h0, 3'd3, 2'b00};
    apb.pwrite_i  = 1'b1;
    apb.pwdata_i  = 32'h0BAD_F00D;
    apb.psel_i    = 1'b1;
    apb.penable_i = 1'b0;
    @(posedge clk); #1;
    apb.penable_i = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("req_before_rel", fll_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    apb.psel_i    = 1'b0;
    apb.penable_i = 1'b0;
    @(negedge clk);
    chk("release_req", fll_req, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", fll_req, 0);
    chk("post_rst_pready", apb.pready_o, 0);
    chk("post_rst_add", fll_add, 0);
    chk("post_rst_wrn", fll_wrn, 1);
    chk("post_rst_data", fll_data, 0);
    m_lost = 0;
    m_to = 0;
    @(posedge clk); #1;
    fork
      bus(3'd3, 1'b1, 32'h0BAD_F00D, lat);
      begin
        repeat (3) @(posedge clk); #1;
        ack_mode = 1'b0;
      end
    join
    chk("stall_latency", lat, 11);
    chk("stall_data_lit", fll_data, 32'h0BAD_F00D);
    exp_fll = 0;

`ifdef FLL_CFG_TIMEOUT_EN
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    exp_fll  = 1;
    exp_err  = 1;
    exp_read = 0;
    exp_add  = 2'd0;
    exp_wrn  = 0;
    m_data   = 32'h0000_0011;
    bus(3'd0, 1'b1, 32'h0000_0011, lat);
    chk("timeout_latency", lat, 17);
    chk("timeout_req_low", fll_req, 0);
    exp_fll = 0;
    exp_err = 0;
    ack_mode = 1'b0;
    m_to = 1;
    repeat (4) @(posedge clk); #1;
    st_rd();
    chk("timeout_bit_lit", apb.prdata_o, 32'h4);
    st_wr(32'h4);
    st_rd();
    chk("timeout_clr_lit", apb.prdata_o, 32'h0);
`else
    st_wr(32'h6);
    st_rd();
    chk("no_timeout_bit", apb.prdata_o, 32'h0);
`endif

    fll_txn(2'd1, 1'b0, 32'h8765_4321, 7);
    chk("final_rd_lit", apb.prdata_o, 32'h8765_4321);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
